// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: retires ALU results, sequences CSR accesses through a
// two-state handshake, reports exceptions and keeps the retired-instruction count.
module wb_commit_unit (
  input  logic        CLK,
  input  logic        RST,
  // writeback latch
  input  logic        PC_VALID_TO_WB,
  input  logic [39:0] PC_TO_WB,
  input  logic [31:0] INST_TO_WB,
  input  logic        WE_TO_WB,
  input  logic [63:0] DATA_TO_WB,
  input  logic [4:0]  ADDR_TO_WB,
  input  logic        WB_CSR_ENABLE,
  input  logic [63:0] DATA_TO_CSR,
  input  logic        WB_XCPT,
  input  logic [63:0] WB_XCPT_CAUSE,
  input  logic [39:0] WB_REQ_BITS_ADDR,
  // CSR unit
  output logic        CSR_REQ,
  output logic [11:0] CSR_ADDR,
  output logic [63:0] CSR_WDATA,
  input  logic        CSR_READY,
  input  logic [63:0] CSR_RDATA,
  // register file
  output logic        RF_WE,
  output logic [4:0]  RF_WADDR,
  output logic [63:0] RF_WDATA,
  // pipeline control
  output logic        LOCK_TO_LATCH,
  output logic        FLUSH_TO_LATCH,
  // exception report
  output logic        XCPT_VALID,
  output logic [39:0] XCPT_EPC,
  output logic [63:0] XCPT_CAUSE,
  output logic [39:0] XCPT_TVAL,
  // counters
  output logic [63:0] INSTRET
);

  typedef enum logic {
    IDLE     = 1'b0,
    CSR_WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        csr_req_q, csr_req_d;
  logic [11:0] csr_addr_q, csr_addr_d;
  logic [63:0] csr_wdata_q, csr_wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        rd_we_q, rd_we_d;
  logic        xcpt_valid_q, xcpt_valid_d;
  logic [39:0] xcpt_epc_q, xcpt_epc_d;
  logic [63:0] xcpt_cause_q, xcpt_cause_d;
  logic [39:0] xcpt_tval_q, xcpt_tval_d;
  logic [63:0] instret_q, instret_d;

  logic        rf_we, lock, flush, retire;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    csr_req_d    = csr_req_q;
    csr_addr_d   = csr_addr_q;
    csr_wdata_d  = csr_wdata_q;
    rd_d         = rd_q;
    rd_we_d      = rd_we_q;
    xcpt_valid_d = 1'b0;
    xcpt_epc_d   = xcpt_epc_q;
    xcpt_cause_d = xcpt_cause_q;
    xcpt_tval_d  = xcpt_tval_q;
    rf_we        = 1'b0;
    RF_WADDR     = ADDR_TO_WB;
    RF_WDATA     = DATA_TO_WB;
    lock         = 1'b0;
    flush        = 1'b0;
    retire       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (PC_VALID_TO_WB) begin
          if (WB_XCPT) begin
            // exception wins over CSR and register writes for this slot
            flush        = 1'b1;
            xcpt_valid_d = 1'b1;
            xcpt_epc_d   = PC_TO_WB;
            xcpt_cause_d = WB_XCPT_CAUSE;
            xcpt_tval_d  = WB_REQ_BITS_ADDR;
          end else if (WB_CSR_ENABLE) begin
            lock        = 1'b1;
            csr_req_d   = 1'b1;
            csr_addr_d  = INST_TO_WB[31:20];
            csr_wdata_d = DATA_TO_CSR;
            rd_d        = ADDR_TO_WB;
            rd_we_d     = WE_TO_WB;
            state_d     = CSR_WAIT;
          end else begin
            rf_we  = WE_TO_WB & (|ADDR_TO_WB);
            retire = 1'b1;
          end
        end
      end
      CSR_WAIT: begin
        // latch-side inputs are deliberately not looked at while waiting
        if (CSR_READY) begin
          rf_we     = rd_we_q & (|rd_q);
          RF_WADDR  = rd_q;
          RF_WDATA  = CSR_RDATA;
          retire    = 1'b1;
          csr_req_d = 1'b0;
          state_d   = IDLE;
        end else begin
          lock = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    instret_d = instret_q + {63'd0, retire};
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  // NOTE: all state, including the captured CSR/exception payloads, is reset so
  // outputs are defined from the first cycle after reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      csr_req_q    <= 1'b0;
      csr_addr_q   <= '0;
      csr_wdata_q  <= '0;
      rd_q         <= '0;
      rd_we_q      <= 1'b0;
      xcpt_valid_q <= 1'b0;
      xcpt_epc_q   <= '0;
      xcpt_cause_q <= '0;
      xcpt_tval_q  <= '0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      csr_req_q    <= csr_req_d;
      csr_addr_q   <= csr_addr_d;
      csr_wdata_q  <= csr_wdata_d;
      rd_q         <= rd_d;
      rd_we_q      <= rd_we_d;
      xcpt_valid_q <= xcpt_valid_d;
      xcpt_epc_q   <= xcpt_epc_d;
      xcpt_cause_q <= xcpt_cause_d;
      xcpt_tval_q  <= xcpt_tval_d;
      instret_q    <= instret_d;
    end
  end

  // combinational strobes are forced low while reset is held, which also
  // aborts an in-flight CSR access without a register write
  assign RF_WE          = rf_we & RST;
  assign LOCK_TO_LATCH  = lock  & RST;
  assign FLUSH_TO_LATCH = flush & RST;

  assign CSR_REQ    = csr_req_q;
  assign CSR_ADDR   = csr_addr_q;
  assign CSR_WDATA  = csr_wdata_q;
  assign XCPT_VALID = xcpt_valid_q;
  assign XCPT_EPC   = xcpt_epc_q;
  assign XCPT_CAUSE = xcpt_cause_q;
  assign XCPT_TVAL  = xcpt_tval_q;
  assign INSTRET    = instret_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit: inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_wb_commit_unit;

  logic        CLK, RST;
  logic        PC_VALID_TO_WB;
  logic [39:0] PC_TO_WB;
  logic [31:0] INST_TO_WB;
  logic        WE_TO_WB;
  logic [63:0] DATA_TO_WB;
  logic [4:0]  ADDR_TO_WB;
  logic        WB_CSR_ENABLE;
  logic [63:0] DATA_TO_CSR;
  logic        WB_XCPT;
  logic [63:0] WB_XCPT_CAUSE;
  logic [39:0] WB_REQ_BITS_ADDR;
  logic        CSR_REQ;
  logic [11:0] CSR_ADDR;
  logic [63:0] CSR_WDATA;
  logic        CSR_READY;
  logic [63:0] CSR_RDATA;
  logic        RF_WE;
  logic [4:0]  RF_WADDR;
  logic [63:0] RF_WDATA;
  logic        LOCK_TO_LATCH, FLUSH_TO_LATCH;
  logic        XCPT_VALID;
  logic [39:0] XCPT_EPC;
  logic [63:0] XCPT_CAUSE;
  logic [39:0] XCPT_TVAL;
  logic [63:0] INSTRET;

  int          vectors = 0;
  int          errors  = 0;
  logic [63:0] exp_instret;

  wb_commit_unit dut (
    .CLK(CLK), .RST(RST),
    .PC_VALID_TO_WB(PC_VALID_TO_WB), .PC_TO_WB(PC_TO_WB), .INST_TO_WB(INST_TO_WB),
    .WE_TO_WB(WE_TO_WB), .DATA_TO_WB(DATA_TO_WB), .ADDR_TO_WB(ADDR_TO_WB),
    .WB_CSR_ENABLE(WB_CSR_ENABLE), .DATA_TO_CSR(DATA_TO_CSR), .WB_XCPT(WB_XCPT),
    .WB_XCPT_CAUSE(WB_XCPT_CAUSE), .WB_REQ_BITS_ADDR(WB_REQ_BITS_ADDR),
    .CSR_REQ(CSR_REQ), .CSR_ADDR(CSR_ADDR), .CSR_WDATA(CSR_WDATA),
    .CSR_READY(CSR_READY), .CSR_RDATA(CSR_RDATA),
    .RF_WE(RF_WE), .RF_WADDR(RF_WADDR), .RF_WDATA(RF_WDATA),
    .LOCK_TO_LATCH(LOCK_TO_LATCH), .FLUSH_TO_LATCH(FLUSH_TO_LATCH),
    .XCPT_VALID(XCPT_VALID), .XCPT_EPC(XCPT_EPC), .XCPT_CAUSE(XCPT_CAUSE),
    .XCPT_TVAL(XCPT_TVAL), .INSTRET(INSTRET)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic idle_slot();
    PC_VALID_TO_WB = 0; PC_TO_WB = '0; INST_TO_WB = '0; WE_TO_WB = 0;
    DATA_TO_WB = '0; ADDR_TO_WB = '0; WB_CSR_ENABLE = 0; DATA_TO_CSR = '0;
    WB_XCPT = 0; WB_XCPT_CAUSE = '0; WB_REQ_BITS_ADDR = '0;
  endtask

  task automatic alu_slot(input logic [4:0] addr, input logic we, input logic [63:0] data);
    idle_slot();
    PC_VALID_TO_WB = 1; ADDR_TO_WB = addr; WE_TO_WB = we; DATA_TO_WB = data;
  endtask

  task automatic csr_slot(input logic [11:0] csr, input logic [4:0] rd, input logic [63:0] wdata);
    idle_slot();
    PC_VALID_TO_WB = 1; WB_CSR_ENABLE = 1; INST_TO_WB = {csr, 20'h00073};
    ADDR_TO_WB = rd; WE_TO_WB = 1; DATA_TO_CSR = wdata;
  endtask

  task automatic test_reset();
    RST = 0; CSR_READY = 0; CSR_RDATA = '0;
    alu_slot(5'd3, 1'b1, 64'h1234);
    WB_CSR_ENABLE = 1; WB_XCPT = 1;
    #1;
    vectors++; if (RF_WE !== 1'b0) begin errors++; $display("FAIL rst_rf_we: got %b want 0", RF_WE); end
    vectors++; if (LOCK_TO_LATCH !== 1'b0) begin errors++; $display("FAIL rst_lock: got %b want 0", LOCK_TO_LATCH); end
    vectors++; if (FLUSH_TO_LATCH !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b want 0", FLUSH_TO_LATCH); end
    repeat (2) @(negedge CLK);
    #1;
    vectors++; if (CSR_REQ !== 1'b0) begin errors++; $display("FAIL rst_csr_req: got %b want 0", CSR_REQ); end
    vectors++; if (XCPT_VALID !== 1'b0) begin errors++; $display("FAIL rst_xcpt_valid: got %b want 0", XCPT_VALID); end
    vectors++; if (INSTRET !== 64'd0) begin errors++; $display("FAIL rst_instret: got %h want 0", INSTRET); end
    vectors++; if ({XCPT_EPC, XCPT_CAUSE, XCPT_TVAL, CSR_ADDR, CSR_WDATA} !== '0) begin
      errors++; $display("FAIL rst_payload: got %h %h %h %h %h want all 0", XCPT_EPC, XCPT_CAUSE, XCPT_TVAL, CSR_ADDR, CSR_WDATA);
    end
    @(negedge CLK);
    idle_slot();
    RST = 1;
    exp_instret = 64'd0;
  endtask

  task automatic test_alu_write();
    @(negedge CLK);
    alu_slot(5'd5, 1'b1, 64'hDEAD);
    #1;
    vectors++; if (RF_WE !== 1'b1) begin errors++; $display("FAIL alu_rf_we: got %b want 1", RF_WE); end
    vectors++; if (RF_WADDR !== 5'd5) begin errors++; $display("FAIL alu_waddr: got %0d want 5", RF_WADDR); end
    vectors++; if (RF_WDATA !== 64'hDEAD) begin errors++; $display("FAIL alu_wdata: got %h want dead", RF_WDATA); end
    vectors++; if ({LOCK_TO_LATCH, FLUSH_TO_LATCH} !== 2'b00) begin errors++; $display("FAIL alu_lock_flush: got %b want 00", {LOCK_TO_LATCH, FLUSH_TO_LATCH}); end
    @(negedge CLK);
    idle_slot();
    exp_instret = 64'd1;
    #1;
    vectors++; if (INSTRET !== exp_instret) begin errors++; $display("FAIL alu_instret: got %h want %h", INSTRET, exp_instret); end
  endtask

  task automatic test_x0_write();
    @(negedge CLK);
    alu_slot(5'd0, 1'b1, 64'hFFFF);
    #1;
    vectors++; if (RF_WE !== 1'b0) begin errors++; $display("FAIL x0_rf_we: got %b want 0", RF_WE); end
    @(negedge CLK);
    idle_slot();
    exp_instret = exp_instret + 1;
    #1;
    vectors++; if (INSTRET !== exp_instret) begin errors++; $display("FAIL x0_instret: got %h want %h", INSTRET, exp_instret); end
  endtask

  task automatic test_invalid_slot();
    @(negedge CLK);
    alu_slot(5'd6, 1'b1, 64'h77);
    PC_VALID_TO_WB = 0; WB_CSR_ENABLE = 1; WB_XCPT = 1;
    #1;
    vectors++; if ({RF_WE, LOCK_TO_LATCH, FLUSH_TO_LATCH} !== 3'b000) begin
      errors++; $display("FAIL invalid_strobes: got %b want 000", {RF_WE, LOCK_TO_LATCH, FLUSH_TO_LATCH});
    end
    @(negedge CLK);
    idle_slot();
    #1;
    vectors++; if (INSTRET !== exp_instret) begin errors++; $display("FAIL invalid_instret: got %h want %h", INSTRET, exp_instret); end
    vectors++; if ({CSR_REQ, XCPT_VALID} !== 2'b00) begin errors++; $display("FAIL invalid_req_xcpt: got %b want 00", {CSR_REQ, XCPT_VALID}); end
  endtask

  task automatic test_csr();
    int lock_cycles = 0;
    int req_wait_cycles = 0;
    @(negedge CLK);
    csr_slot(12'h300, 5'd7, 64'h8);
    #1;
    lock_cycles += int'(LOCK_TO_LATCH);
    vectors++; if ({RF_WE, CSR_REQ, FLUSH_TO_LATCH} !== 3'b000) begin
      errors++; $display("FAIL csr_issue: rf_we/req/flush got %b want 000", {RF_WE, CSR_REQ, FLUSH_TO_LATCH});
    end
    @(negedge CLK);
    // junk exception slot on the latch must be ignored while waiting
    alu_slot(5'd9, 1'b1, 64'hBEEF);
    WB_XCPT = 1; PC_TO_WB = 40'hABC;
    for (int k = 0; k < 3; k++) begin
      CSR_READY = 0;
      #1;
      lock_cycles += int'(LOCK_TO_LATCH);
      req_wait_cycles += int'(CSR_REQ);
      vectors++; if ({CSR_ADDR, CSR_WDATA} !== {12'h300, 64'h8}) begin
        errors++; $display("FAIL csr_wait_payload: got %h/%h want 300/8", CSR_ADDR, CSR_WDATA);
      end
      vectors++; if ({RF_WE, FLUSH_TO_LATCH} !== 2'b00) begin
        errors++; $display("FAIL csr_wait_strobes: cycle %0d rf_we/flush got %b want 00", k, {RF_WE, FLUSH_TO_LATCH});
      end
      @(negedge CLK);
    end
    CSR_READY = 1; CSR_RDATA = 64'h1800;
    #1;
    lock_cycles += int'(LOCK_TO_LATCH);
    vectors++; if (CSR_REQ !== 1'b1) begin errors++; $display("FAIL csr_ready_req: got %b want 1", CSR_REQ); end
    vectors++; if ({RF_WE, RF_WADDR, RF_WDATA} !== {1'b1, 5'd7, 64'h1800}) begin
      errors++; $display("FAIL csr_ready_write: got we=%b addr=%0d data=%h want 1/7/1800", RF_WE, RF_WADDR, RF_WDATA);
    end
    @(negedge CLK);
    CSR_READY = 0;
    idle_slot();
    exp_instret = exp_instret + 1;
    #1;
    vectors++; if (CSR_REQ !== 1'b0) begin errors++; $display("FAIL csr_req_drop: got %b want 0", CSR_REQ); end
    vectors++; if (INSTRET !== exp_instret) begin errors++; $display("FAIL csr_instret: got %h want %h", INSTRET, exp_instret); end
    vectors++; if (XCPT_VALID !== 1'b0) begin errors++; $display("FAIL csr_ignored_xcpt: got %b want 0", XCPT_VALID); end
    vectors++; if (lock_cycles != 4) begin errors++; $display("FAIL csr_lock_cycles: got %0d want 4", lock_cycles); end
    vectors++; if (req_wait_cycles != 3) begin errors++; $display("FAIL csr_req_cycles: got %0d want 3", req_wait_cycles); end
  endtask

  task automatic test_ready_in_idle();
    @(negedge CLK);
    alu_slot(5'd4, 1'b1, 64'h55);
    CSR_READY = 1; CSR_RDATA = 64'h99;
    #1;
    vectors++; if ({RF_WE, RF_WADDR, RF_WDATA} !== {1'b1, 5'd4, 64'h55}) begin
      errors++; $display("FAIL idle_ready_write: got we=%b addr=%0d data=%h want 1/4/55", RF_WE, RF_WADDR, RF_WDATA);
    end
    @(negedge CLK);
    idle_slot();
    exp_instret = exp_instret + 1;
    #1;
    vectors++; if (INSTRET !== exp_instret) begin errors++; $display("FAIL idle_ready_instret: got %h want %h", INSTRET, exp_instret); end
    vectors++; if (RF_WE !== 1'b0) begin errors++; $display("FAIL idle_ready_nowrite: got %b want 0", RF_WE); end
    @(negedge CLK);
    CSR_READY = 0;
  endtask

  task automatic test_exception();
    @(negedge CLK);
    csr_slot(12'h341, 5'd3, 64'h1);
    WB_XCPT = 1; PC_TO_WB = 40'h1000; WB_XCPT_CAUSE = 64'h5; WB_REQ_BITS_ADDR = 40'h2004;
    #1;
    vectors++; if ({FLUSH_TO_LATCH, LOCK_TO_LATCH, RF_WE} !== 3'b100) begin
      errors++; $display("FAIL xcpt_strobes: flush/lock/rf_we got %b want 100", {FLUSH_TO_LATCH, LOCK_TO_LATCH, RF_WE});
    end
    @(negedge CLK);
    idle_slot();
    #1;
    vectors++; if (XCPT_VALID !== 1'b1) begin errors++; $display("FAIL xcpt_valid: got %b want 1", XCPT_VALID); end
    vectors++; if ({XCPT_EPC, XCPT_CAUSE, XCPT_TVAL} !== {40'h1000, 64'h5, 40'h2004}) begin
      errors++; $display("FAIL xcpt_payload: got %h/%h/%h want 1000/5/2004", XCPT_EPC, XCPT_CAUSE, XCPT_TVAL);
    end
    vectors++; if (CSR_REQ !== 1'b0) begin errors++; $display("FAIL xcpt_no_csr: got %b want 0", CSR_REQ); end
    vectors++; if (INSTRET !== exp_instret) begin errors++; $display("FAIL xcpt_instret: got %h want %h", INSTRET, exp_instret); end
    @(negedge CLK);
    #1;
    vectors++; if (XCPT_VALID !== 1'b0) begin errors++; $display("FAIL xcpt_one_cycle: got %b want 0", XCPT_VALID); end
    vectors++; if (XCPT_EPC !== 40'h1000) begin errors++; $display("FAIL xcpt_epc_hold: got %h want 1000", XCPT_EPC); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  addrs [3] = '{5'd1, 5'd2, 5'd31};
    logic [63:0] datas [3] = '{64'h11, 64'h2222, 64'hFFFF_0000_FFFF_0000};
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      alu_slot(addrs[i], 1'b1, datas[i]);
      #1;
      vectors++; if ({RF_WE, RF_WADDR, RF_WDATA} !== {1'b1, addrs[i], datas[i]}) begin
        errors++; $display("FAIL b2b_write%0d: got we=%b addr=%0d data=%h want 1/%0d/%h", i, RF_WE, RF_WADDR, RF_WDATA, addrs[i], datas[i]);
      end
    end
    @(negedge CLK);
    idle_slot();
    exp_instret = exp_instret + 3;
    #1;
    vectors++; if (INSTRET !== exp_instret) begin errors++; $display("FAIL b2b_instret: got %h want %h", INSTRET, exp_instret); end
  endtask

  task automatic test_wrap();
    @(negedge CLK);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.instret_q;
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFE;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      alu_slot(5'd8, 1'b1, 64'h1);
      @(negedge CLK);
      idle_slot();
      exp_instret = exp_instret + 1;
      #1;
      vectors++; if (INSTRET !== exp_instret) begin errors++; $display("FAIL wrap_step%0d: got %h want %h", i, INSTRET, exp_instret); end
    end
  endtask

  task automatic test_reset_mid_csr();
    @(negedge CLK);
    csr_slot(12'h305, 5'd9, 64'h42);
    @(negedge CLK);
    idle_slot();
    CSR_READY = 0;
    @(negedge CLK);
    RST = 0; CSR_READY = 1; CSR_RDATA = 64'hBAD;
    #1;
    vectors++; if (CSR_REQ !== 1'b0) begin errors++; $display("FAIL rstcsr_req: got %b want 0", CSR_REQ); end
    vectors++; if ({RF_WE, LOCK_TO_LATCH} !== 2'b00) begin errors++; $display("FAIL rstcsr_strobes: got %b want 00", {RF_WE, LOCK_TO_LATCH}); end
    @(negedge CLK);
    RST = 1;
    exp_instret = 64'd0;
    #1;
    vectors++; if ({RF_WE, LOCK_TO_LATCH} !== 2'b00) begin errors++; $display("FAIL rstcsr_release: got %b want 00", {RF_WE, LOCK_TO_LATCH}); end
    @(negedge CLK);
    #1;
    vectors++; if ({CSR_REQ, CSR_ADDR} !== {1'b0, 12'h000}) begin errors++; $display("FAIL rstcsr_idle: req/addr got %b/%h want 0/000", CSR_REQ, CSR_ADDR); end
    vectors++; if (INSTRET !== exp_instret) begin errors++; $display("FAIL rstcsr_instret: got %h want %h", INSTRET, exp_instret); end
    CSR_READY = 0;
  endtask

  initial begin
    idle_slot();
    test_reset();
    test_alu_write();
    test_x0_write();
    test_invalid_slot();
    test_csr();
    test_ready_in_idle();
    test_exception();
    test_back_to_back();
    test_wrap();
    test_reset_mid_csr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
